// File: rtl/dtc_stub_pkg.sv
// Shared definitions for the DTC stub router: default field widths, the FSM state
// encoding and the helper that locates stub k inside a frame.
package dtc_stub_pkg;

  localparam int unsigned HDR_W_DEF  = 26;
  localparam int unsigned STUB_W_DEF = 21;
  localparam int unsigned CID_W_DEF  = 3;

  typedef enum logic {
    StIdle   = 1'b0,
    StUnpack = 1'b1
  } state_e;

  // MSB index of stub k. Stubs are packed MSB-first directly below the header.
  function automatic int unsigned stub_msb(input int unsigned frame_w,
                                           input int unsigned hdr_w,
                                           input int unsigned stub_w,
                                           input int unsigned k);
    return frame_w - hdr_w - 1 - k * stub_w;
  endfunction

endpackage

// File: rtl/dtc_stub_fifo.sv
// Single-clock FIFO holding the stubs routed to one chip. The read word is shown
// combinationally at dout_o. A push to a full FIFO or a pop from an empty one is ignored.
module dtc_stub_fifo #(
  parameter int unsigned WIDTH      = 21,
  parameter int unsigned DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (DEPTH_LOG2 + 1)'(Depth));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign level_o = level_q;

  // Storage array. Contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Pointers wrap modulo the depth. A push and a pop in the same cycle leave the level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/dtc_stub_router.sv
// DTC stub router. It accepts a concentrator frame and unpacks one stub per cycle.
// Each stub is routed by its chip-ID into a per-chip FIFO, and the block counts drops.
// Optional build macro DTC_STUB_NULL_DROP_EN makes the router discard null stubs
// silently. A null stub has all-zero bits below its chip-ID.
module dtc_stub_router
  import dtc_stub_pkg::*;
#(
  parameter int unsigned FRAME_W    = 256,
  parameter int unsigned HDR_W      = HDR_W_DEF,
  parameter int unsigned STUB_W     = STUB_W_DEF,
  parameter int unsigned N_STUBS    = 10,
  parameter int unsigned CID_W      = CID_W_DEF,
  parameter int unsigned N_CHIPS    = 8,
  parameter int unsigned DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_W-1:0]    frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [CID_W-1:0]      rd_chip,
  input  logic                  rd_en,
  output logic [STUB_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   rd_level,
  output logic [N_CHIPS-1:0]    chip_empty,
  output logic [N_CHIPS-1:0]    chip_full,
  output logic [N_CHIPS-1:0]    ovf_sticky,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned IdxW = (N_STUBS > 1) ? $clog2(N_STUBS) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(N_STUBS - 1);
  localparam logic [CID_W:0]   NChips  = (CID_W + 1)'(N_CHIPS);

  state_e               state_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [IdxW-1:0]      idx_q;
  logic                 frame_ready_q;
  logic [15:0]          frame_cnt_q, drop_cnt_q;
  logic [N_CHIPS-1:0]   ovf_q;
  logic [STUB_W-1:0]    rd_data_q;
  logic                 rd_valid_q;

  logic [STUB_W-1:0]    stubs [N_STUBS];
  logic [STUB_W-1:0]    cur_stub;
  logic [CID_W-1:0]     cid;
  logic                 cid_ok, is_null, route_ok, drop;
  logic                 rd_ok;
  logic [N_CHIPS-1:0]   push_vec, pop_vec, ovf_set, fifo_empty, fifo_full;
  logic [STUB_W-1:0]    fifo_dout  [N_CHIPS];
  logic [DEPTH_LOG2:0]  fifo_level [N_CHIPS];

  for (genvar k = 0; k < N_STUBS; k++) begin : g_stub
    assign stubs[k] = frame_q[stub_msb(FRAME_W, HDR_W, STUB_W, k) -: STUB_W];
  end

  assign cur_stub = stubs[idx_q];
  assign cid      = cur_stub[STUB_W-1 -: CID_W];
  assign cid_ok   = ({1'b0, cid} < NChips);
  assign route_ok = (state_q == StUnpack) && !is_null;
  assign rd_ok    = ({1'b0, rd_chip} < NChips);

`ifdef DTC_STUB_NULL_DROP_EN
  assign is_null = (cur_stub[STUB_W-CID_W-1:0] == '0);
`else
  assign is_null = 1'b0;
`endif

  // Per-chip push, overflow and pop decode. The full check uses the level before any pop in the same cycle.
  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    ovf_set  = '0;
    for (int c = 0; c < N_CHIPS; c++) begin
      push_vec[c] = route_ok && cid_ok && (cid == CID_W'(c)) && !fifo_full[c];
      ovf_set[c]  = route_ok && cid_ok && (cid == CID_W'(c)) && fifo_full[c];
      pop_vec[c]  = rd_en && (rd_chip == CID_W'(c)) && !fifo_empty[c];
    end
    drop = route_ok && (!cid_ok || (|ovf_set));
  end

  for (genvar c = 0; c < N_CHIPS; c++) begin : g_fifo
    dtc_stub_fifo #(
      .WIDTH      (STUB_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_vec[c]),
      .din_i   (cur_stub),
      .pop_i   (pop_vec[c]),
      .dout_o  (fifo_dout[c]),
      .level_o (fifo_level[c]),
      .empty_o (fifo_empty[c]),
      .full_o  (fifo_full[c])
    );
  end

  // Frame FSM. IDLE latches a frame. UNPACK walks idx from 0 to N_STUBS-1 and then returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      frame_q       <= '0;
      idx_q         <= '0;
      frame_ready_q <= 1'b1;
      frame_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (frame_valid && frame_ready_q) begin
            frame_q       <= frame_in;
            idx_q         <= '0;
            frame_cnt_q   <= frame_cnt_q + 16'd1;
            frame_ready_q <= 1'b0;
            state_q       <= StUnpack;
          end
        end
        StUnpack: begin
          if (idx_q == LastIdx) begin
            state_q       <= StIdle;
            frame_ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Drop statistics. The drop counter saturates, and the overflow flags stay set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      ovf_q      <= '0;
    end else begin
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      ovf_q <= ovf_q | ovf_set;
    end
  end

  // Registered readout. rd_data keeps its value when no pop occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= |pop_vec;
      if (|pop_vec) rd_data_q <= fifo_dout[rd_chip];
    end
  end

  // Occupancy of the selected FIFO, or zero when no such chip exists.
  always_comb begin
    rd_level = '0;
    if (rd_ok) rd_level = fifo_level[rd_chip];
  end

  assign frame_ready = frame_ready_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign ovf_sticky  = ovf_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign chip_empty  = fifo_empty;
  assign chip_full   = fifo_full;

endmodule

// File: doc/dtc_stub_router.md
Name: dtc_stub_router

Overview:
- Parametrised successor to the DTC capture path. It accepts parallel concentrator frames through a valid/ready handshake.
- It unpacks N_STUBS fixed-width stubs per frame and routes each stub, by its chip-ID field, into one of N_CHIPS per-chip FIFOs.
- Each FIFO can be read out independently, and the block reports overflow and bad-ID statistics.
- It sits between the frame deserialiser and the per-MPA stub storage and readout logic.

Parameters:
- FRAME_W, 256: frame width in bits.
- HDR_W, 26: header bits at the frame MSBs; not routed.
- STUB_W, 21: stub width; stored as-is.
- N_STUBS, 10: stubs per frame; HDR_W + N_STUBS*STUB_W <= FRAME_W.
- CID_W, 3: chip-ID field width; occupies the top CID_W bits of each stub.
- N_CHIPS, 8: number of per-chip FIFOs; N_CHIPS <= 2**CID_W.
- DEPTH_LOG2, 7: log2 of the per-chip FIFO depth (128 entries).

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- frame_in, in, FRAME_W: input frame.
- frame_valid, in, 1: frame_in is valid.
- frame_ready, out, 1: block can accept a frame.
- rd_chip, in, CID_W: FIFO selected for readout.
- rd_en, in, 1: pop one word from FIFO rd_chip.
- rd_data, out, STUB_W: popped stub.
- rd_valid, out, 1: rd_data is valid.
- rd_level, out, DEPTH_LOG2+1: occupancy of FIFO rd_chip (combinational).
- chip_empty, out, N_CHIPS: per-FIFO empty flags.
- chip_full, out, N_CHIPS: per-FIFO full flags.
- ovf_sticky, out, N_CHIPS: per-chip sticky "stub dropped because FIFO full" flag.
- drop_cnt, out, 16: total dropped stubs (overflow plus bad ID); saturates at 0xFFFF.
- frame_cnt, out, 16: frames accepted; wraps.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; all FIFO pointers and levels are 0.
  - rd_data=0, rd_valid=0, ovf_sticky=0, drop_cnt=0, frame_cnt=0.
  - chip_empty all 1, chip_full all 0, frame_ready=1.
  - Reset mid-frame discards that frame and all FIFO contents.
- FSM states: IDLE and UNPACK.
- IDLE:
  - frame_ready=1.
  - On frame_valid&&frame_ready: latch frame_in into frame_reg, set idx=0, frame_cnt+=1, go to UNPACK.
- UNPACK:
  - frame_ready=0.
  - Stub k = frame_reg[FRAME_W-HDR_W-1-k*STUB_W -: STUB_W].
  - cid = stub[STUB_W-1 -: CID_W].
  - One stub is processed per cycle. When idx==N_STUBS-1, return to IDLE.
  - Throughput: one frame per N_STUBS+1 cycles (11 at defaults).
- Routing per stub:
  - cid >= N_CHIPS: discard, drop_cnt+=1.
  - FIFO cid full: discard, set ovf_sticky[cid], drop_cnt+=1.
  - Otherwise: push the stub into FIFO cid.
  - The full check uses the level before this cycle's pop. A simultaneous pop on the same chip does not free space within that cycle.
- Readout:
  - rd_en with FIFO rd_chip non-empty: pop; rd_data/rd_valid are registered and valid 1 cycle later.
  - rd_en on an empty FIFO is ignored: rd_valid=0 and rd_data holds its value.
  - rd_valid is a single-cycle pulse per pop.
- Simultaneous push and pop on the same FIFO: both occur and the level is unchanged.
- FIFO behaviour: pointers are DEPTH_LOG2 bits and wrap modulo depth; the level counter is DEPTH_LOG2+1 bits.
- ovf_sticky clears only on rst.
- drop_cnt saturates and never wraps.

Optional Feature:
- Macro: DTC_STUB_NULL_DROP_EN.
- Defined: a stub whose bits below the chip-ID field are all zero is a null stub. It is discarded silently: no push, no drop_cnt increment, no sticky flag.
- Undefined: null stubs are routed like any other stub.

Decomposition:
- Shared package dtc_stub_pkg holds:
  - default widths (STUB_W, CID_W, HDR_W);
  - the FSM state encoding (IDLE=1'b0, UNPACK=1'b1);
  - the stub-offset function, returning the MSB index for stub k.
- Sub-module dtc_stub_fifo: a synchronous single-clock FIFO (width STUB_W, depth 2**DEPTH_LOG2) with push, pop, dout, level, empty, full and async rst. It is instantiated N_CHIPS times in a generate loop.
- The top level holds the FSM, extract/route logic, readout mux and counters.

Test Plan:
- Reset, then one frame with stubs k=0..9 having cid=k%8 and payload=k+1:
  - FIFOs 0 and 1 reach level 2; FIFOs 2..7 reach level 1.
  - frame_ready is low for 10 cycles; frame_cnt=1.
  - Reading chip 1 twice returns payloads 2 then 10, in that order.
- With N_CHIPS=6, one frame with all stubs cid=7: no FIFO changes and drop_cnt=10.
- Back-to-back frames with all 10 stubs cid=3 and frame_valid held high:
  - One frame is accepted every 11 cycles.
  - After 13 frames, FIFO 3 is full at 128 and drop_cnt=2.
  - ovf_sticky=8'b0000_1000; chip_full[3]=1.
- Pop chip 3 on every cycle during a frame targeting chip 3 at level 128:
  - The first stub is dropped (level check precedes the pop).
  - After that, the level stays constant; rd_valid pulses 1 cycle after each rd_en.
- rd_en on empty chip 5: rd_valid stays 0 and rd_data is unchanged.
- rst asserted mid-UNPACK:
  - Outputs are immediately at reset values; all chip_empty=1.
  - With DTC_STUB_NULL_DROP_EN defined, a frame of all-zero stubs afterwards leaves every FIFO empty and drop_cnt=0.
